// File: rtl/forwarding_scoreboard.sv
// Operand bypass selection plus an in-flight write scoreboard that holds
// decode until long-latency results become forwardable.

// Per-source bypass select: EX/MEM beats MEM/WB, register 0 never forwarded.
module fwdSel #(
   parameter int ADDR_W = 5
) (
   input  logic [ADDR_W-1:0] src,
   input  logic [ADDR_W-1:0] exMemRd,
   input  logic              exMemRegWrite,
   input  logic [ADDR_W-1:0] memWbRd,
   input  logic              memWbRegWrite,
   output logic [1:0]        sel
);
   // Priority mux on destination match.
   always_comb begin
      sel = 2'b00;
      if (src != '0) begin
         if (exMemRegWrite && (exMemRd == src))      sel = 2'b10;
         else if (memWbRegWrite && (memWbRd == src)) sel = 2'b01;
      end
   end
endmodule

// One scoreboard slot: tracks a pending destination and its countdown.
module sbEntry #(
   parameter int ADDR_W  = 5,
   parameter int NUM_SRC = 2,
   parameter int LAT_W   = 3
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      alloc,
   input  logic [ADDR_W-1:0]         allocRd,
   input  logic [LAT_W-1:0]          allocLat,
   input  logic [NUM_SRC*ADDR_W-1:0] idSrc,
   input  logic [NUM_SRC-1:0]        idSrcUsed,
   output logic                      valid,
   output logic                      nextValid,
   output logic                      hit
);
   logic [ADDR_W-1:0] rd;
   logic [LAT_W-1:0]  count;

   // Slot state: load on allocate, count down, retire once count reaches 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid <= 1'b0;
         rd    <= '0;
         count <= '0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (alloc) begin
         valid <= 1'b1;
         rd    <= allocRd;
         count <= allocLat;
      end else if (valid) begin
         if (count == '0) valid <= 1'b0;
         else             count <= count - 1'b1;
      end
   end

   // Occupancy after this edge, used by the registered population count.
   always_comb begin
      nextValid = 1'b0;
      if (reset || flush) nextValid = 1'b0;
      else if (alloc)     nextValid = 1'b1;
      else                nextValid = valid && (count != '0);
   end

   // A used, nonzero decode source matching a still-counting slot blocks issue.
   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (idSrcUsed[i] && (idSrc[i*ADDR_W +: ADDR_W] != '0) && valid &&
             (rd == idSrc[i*ADDR_W +: ADDR_W]) && (count != '0))
            hit = 1'b1;
      end
   end
endmodule

module forwarding_scoreboard #(
   parameter int ADDR_W  = 5,
   parameter int NUM_SRC = 2,
   parameter int DEPTH   = 4,
   parameter int LAT_W   = 3,
   localparam int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_SRC*ADDR_W-1:0] idSrc,
   input  logic [NUM_SRC-1:0]        idSrcUsed,
   input  logic [NUM_SRC*ADDR_W-1:0] idExSrc,
   input  logic [ADDR_W-1:0]         exMemRd,
   input  logic                      exMemRegWrite,
   input  logic [ADDR_W-1:0]         memWbRd,
   input  logic                      memWbRegWrite,
   input  logic                      issueValid,
   input  logic [ADDR_W-1:0]         issueRd,
   input  logic                      issueRegWrite,
   input  logic [LAT_W-1:0]          issueLatency,
   input  logic                      flush,
   output logic [2*NUM_SRC-1:0]      operandControl,
   output logic                      stall,
   output logic                      issueAccept,
   output logic [CNT_W-1:0]          pendingCount
);
   logic [DEPTH-1:0] entValid, entNext, entHit, allocOh;
   logic             hazard, full, needEntry, allocReq;
   logic [CNT_W-1:0] nextCount;

   for (genvar g = 0; g < NUM_SRC; g++) begin : gSrc
      fwdSel #(.ADDR_W(ADDR_W)) uFwd (
         .src           (idExSrc[g*ADDR_W +: ADDR_W]),
         .exMemRd       (exMemRd),
         .exMemRegWrite (exMemRegWrite),
         .memWbRd       (memWbRd),
         .memWbRegWrite (memWbRegWrite),
         .sel           (operandControl[2*g +: 2])
      );
   end

   for (genvar e = 0; e < DEPTH; e++) begin : gEnt
      sbEntry #(.ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC), .LAT_W(LAT_W)) uEnt (
         .clk       (clk),
         .reset     (reset),
         .flush     (flush),
         .alloc     (allocOh[e]),
         .allocRd   (issueRd),
         .allocLat  (issueLatency),
         .idSrc     (idSrc),
         .idSrcUsed (idSrcUsed),
         .valid     (entValid[e]),
         .nextValid (entNext[e]),
         .hit       (entHit[e])
      );
   end

   // Issue control; full looks only at registered occupancy so a same-cycle
   // retire cannot be reused before it has actually left.
   always_comb begin
      hazard      = |entHit;
      full        = (pendingCount == CNT_W'(DEPTH));
      needEntry   = issueRegWrite && (issueLatency != '0) && (issueRd != '0);
      stall       = issueValid && !flush && (hazard || (full && needEntry));
      issueAccept = issueValid && !stall && !flush;
      allocReq    = issueAccept && needEntry;
   end

   // Pick the lowest-index free slot for a new long-latency write.
   always_comb begin
      logic taken;
      taken   = 1'b0;
      allocOh = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!entValid[i] && !taken) begin
            allocOh[i] = allocReq;
            taken      = 1'b1;
         end
      end
   end

   // Population count of slots that will be occupied after this edge.
   always_comb begin
      nextCount = '0;
      for (int i = 0; i < DEPTH; i++) nextCount = nextCount + CNT_W'(entNext[i]);
   end

   // Registered occupancy.
   always_ff @(posedge clk) begin
      if (reset) pendingCount <= '0;
      else       pendingCount <= nextCount;
   end
endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Directed plus random checks of forwarding_scoreboard against a
// cycle-numbered model of pending writes.
module tb_forwarding_scoreboard;
   localparam int ADDR_W = 5, NUM_SRC = 2, DEPTH = 4, LAT_W = 3, CNT_W = 3;

   logic clk = 1'b0, reset;
   logic [NUM_SRC*ADDR_W-1:0] idSrc, idExSrc;
   logic [NUM_SRC-1:0] idSrcUsed;
   logic [ADDR_W-1:0] exMemRd, memWbRd, issueRd;
   logic exMemRegWrite, memWbRegWrite, issueValid, issueRegWrite, flush;
   logic [LAT_W-1:0] issueLatency;
   logic [2*NUM_SRC-1:0] operandControl;
   logic stall, issueAccept;
   logic [CNT_W-1:0] pendingCount;

   forwarding_scoreboard #(.ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .LAT_W(LAT_W)) dut (
      .clk(clk), .reset(reset), .idSrc(idSrc), .idSrcUsed(idSrcUsed), .idExSrc(idExSrc),
      .exMemRd(exMemRd), .exMemRegWrite(exMemRegWrite), .memWbRd(memWbRd),
      .memWbRegWrite(memWbRegWrite), .issueValid(issueValid), .issueRd(issueRd),
      .issueRegWrite(issueRegWrite), .issueLatency(issueLatency), .flush(flush),
      .operandControl(operandControl), .stall(stall), .issueAccept(issueAccept),
      .pendingCount(pendingCount));

   always #5 clk = ~clk;

   // A write issued at cycle t with latency L blocks readers during cycles
   // t+1..t+L and holds a slot through cycle t+L+1.
   typedef struct { int rd; int t; int lat; } pendWr_t;
   pendWr_t pend[$];
   int cyc = 0;
   int testCnt = 0, failCnt = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testCnt++;
      assert (obs === exp) else begin
         failCnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int srcOf(input logic [NUM_SRC*ADDR_W-1:0] v, input int i);
      return int'(v[i*ADDR_W +: ADDR_W]);
   endfunction

   function automatic bit mBlocked(input int a);
      foreach (pend[k]) if (pend[k].rd == a && cyc <= pend[k].t + pend[k].lat) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit mHazard();
      for (int i = 0; i < NUM_SRC; i++)
         if (idSrcUsed[i] && srcOf(idSrc, i) != 0 && mBlocked(srcOf(idSrc, i))) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit mNeed();
      return issueRegWrite && issueLatency != 0 && issueRd != 0;
   endfunction

   function automatic bit mStall();
      return issueValid && !flush && (mHazard() || (pend.size() == DEPTH && mNeed()));
   endfunction

   function automatic bit mAccept();
      return issueValid && !mStall() && !flush;
   endfunction

   function automatic logic [2*NUM_SRC-1:0] mFwd();
      logic [2*NUM_SRC-1:0] r;
      r = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         int a;
         a = srcOf(idExSrc, i);
         if (a != 0 && exMemRegWrite && int'(exMemRd) == a)      r[2*i +: 2] = 2'b10;
         else if (a != 0 && memWbRegWrite && int'(memWbRd) == a) r[2*i +: 2] = 2'b01;
      end
      return r;
   endfunction

   task automatic settle(input string tag);
      #4;
      check({tag, ".fwd"},   32'(operandControl), 32'(mFwd()));
      check({tag, ".stall"}, 32'(stall),          32'(mStall()));
      check({tag, ".acc"},   32'(issueAccept),    32'(mAccept()));
      check({tag, ".pend"},  32'(pendingCount),   32'(pend.size()));
   endtask

   task automatic advance();
      bit acc, need;
      acc  = mAccept();
      need = mNeed();
      @(posedge clk);
      #1;
      if (reset || flush) pend.delete();
      else if (acc && need) pend.push_back('{int'(issueRd), cyc, int'(issueLatency)});
      cyc++;
      for (int k = pend.size() - 1; k >= 0; k--)
         if (cyc > pend[k].t + pend[k].lat + 1) pend.delete(k);
   endtask

   task automatic idle();
      idSrc = '0; idSrcUsed = '0; idExSrc = '0;
      exMemRd = '0; exMemRegWrite = 0; memWbRd = '0; memWbRegWrite = 0;
      issueValid = 0; issueRd = '0; issueRegWrite = 0; issueLatency = '0; flush = 0;
   endtask

   task automatic issue(input int rd, input int lat);
      issueValid = 1; issueRegWrite = 1; issueRd = ADDR_W'(rd); issueLatency = LAT_W'(lat);
   endtask

   initial begin
      idle();
      reset = 1;
      @(posedge clk);
      #1;
      reset = 0;
      settle("reset");
      check("reset.pendZero", 32'(pendingCount), 32'd0);
      advance();

      // forwarding priority
      idExSrc = {5'd0, 5'd3}; exMemRd = 3; exMemRegWrite = 1; memWbRd = 3; memWbRegWrite = 1;
      settle("fwdEx");  check("fwdEx.sel", 32'(operandControl[1:0]), 32'd2); advance();
      exMemRegWrite = 0;
      settle("fwdMem"); check("fwdMem.sel", 32'(operandControl[1:0]), 32'd1); advance();
      idExSrc = {5'd3, 5'd0}; exMemRd = 0; exMemRegWrite = 1; memWbRd = 0;
      settle("fwdZero"); check("fwdZero.sel", 32'(operandControl[1:0]), 32'd0);
      check("fwdSrc1.sel", 32'(operandControl[3:2]), 32'd0); advance();
      exMemRd = 3;
      settle("fwdSrc1"); check("fwdSrc1Ex.sel", 32'(operandControl[3:2]), 32'd2); advance();
      idle();

      // load-use
      issue(5, 1);
      settle("luIssue"); check("luIssue.acc", 32'(issueAccept), 32'd1); advance();
      issue(6, 0); idSrc = {5'd0, 5'd5}; idSrcUsed = 2'b01;
      settle("luStall"); check("luStall.stall", 32'(stall), 32'd1);
      check("luStall.acc", 32'(issueAccept), 32'd0); advance();
      settle("luGo"); check("luGo.stall", 32'(stall), 32'd0);
      check("luGo.pend", 32'(pendingCount), 32'd1); advance();
      idle();
      settle("luFree"); check("luFree.pend", 32'(pendingCount), 32'd0); advance();

      // multi-cycle dependence
      issue(7, 4); settle("mcIssue"); advance();
      issue(10, 0); idSrc = {5'd0, 5'd7}; idSrcUsed = 2'b01;
      for (int i = 0; i < 4; i++) begin
         settle("mcHold"); check("mcHold.stall", 32'(stall), 32'd1); advance();
      end
      settle("mcGo"); check("mcGo.stall", 32'(stall), 32'd0); advance();
      idle();
      issue(7, 4); settle("mcIssue2"); advance();
      issue(11, 0); idSrc = {5'd0, 5'd8}; idSrcUsed = 2'b01;
      settle("mcIndep"); check("mcIndep.stall", 32'(stall), 32'd0);
      check("mcIndep.acc", 32'(issueAccept), 32'd1); advance();
      idle();
      for (int i = 0; i < 6; i++) begin settle("mcDrain"); advance(); end

      // scoreboard full
      for (int r = 1; r <= 4; r++) begin issue(r, 3); settle("fullFill"); advance(); end
      issue(9, 3);
      settle("fullBlk"); check("fullBlk.pend", 32'(pendingCount), 32'd4);
      check("fullBlk.stall", 32'(stall), 32'd1); advance();
      settle("fullGo"); check("fullGo.acc", 32'(issueAccept), 32'd1);
      check("fullGo.pend", 32'(pendingCount), 32'd3); advance();
      idle();
      for (int i = 0; i < 6; i++) begin settle("fullDrain"); advance(); end

      // flush
      issue(12, 5); settle("flIssue"); advance();
      issue(13, 5); settle("flIssue"); advance();
      issue(14, 2); idSrc = {5'd0, 5'd12}; idSrcUsed = 2'b01;
      settle("flStall"); check("flStall.stall", 32'(stall), 32'd1); advance();
      flush = 1;
      settle("flPulse"); check("flPulse.stall", 32'(stall), 32'd0);
      check("flPulse.acc", 32'(issueAccept), 32'd0); advance();
      idle();
      settle("flAfter"); check("flAfter.pend", 32'(pendingCount), 32'd0); advance();

      // reset mid-countdown
      issue(15, 6); settle("rsIssue"); advance();
      idle(); settle("rsWait"); advance();
      reset = 1; settle("rsPulse"); advance();
      reset = 0; issueValid = 1; idSrc = {5'd0, 5'd15}; idSrcUsed = 2'b01;
      settle("rsAfter"); check("rsAfter.pend", 32'(pendingCount), 32'd0);
      check("rsAfter.stall", 32'(stall), 32'd0); advance();
      idle();

      // random traffic
      for (int n = 0; n < 500; n++) begin
         idSrc = {ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7))};
         idSrcUsed = NUM_SRC'($urandom_range(0, 3));
         idExSrc = {ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7))};
         exMemRd = ADDR_W'($urandom_range(0, 7)); exMemRegWrite = 1'($urandom_range(0, 1));
         memWbRd = ADDR_W'($urandom_range(0, 7)); memWbRegWrite = 1'($urandom_range(0, 1));
         issueValid = ($urandom_range(0, 3) != 0);
         issueRd = ADDR_W'($urandom_range(0, 7)); issueRegWrite = ($urandom_range(0, 4) != 0);
         issueLatency = LAT_W'($urandom_range(0, 5));
         flush = ($urandom_range(0, 24) == 0);
         reset = ($urandom_range(0, 63) == 0);
         settle("rnd");
         advance();
      end
      reset = 0;

      $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
      $finish;
   end
endmodule
